result_collector: RTL

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 101 ++++++++++
 1 files changed

// File: rtl/result_collector.sv
// Result collector: small FIFO between an upstream pipeline register and a downstream sink.
// Latency: a beat pushed into an empty FIFO is presented on Valid_Output the next cycle (head read unregistered).
// Backpressure: Enable_Output = (occupancy < Depth) from registered state only; full blocks pushes even on a concurrent pop.
// Optional feature macro: COLLECTOR_ROW_COUNT_EN enables the Row_Count_Output counter (tied to 0 otherwise).
module result_collector #(
    parameter int Word_Length = 8,
    parameter int Depth       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sys_reset,
    input  logic [Word_Length-1:0] Data_Input,
    input  logic                   Valid_Input,
    input  logic                   Last_Input,
    input  logic                   Flag_Input,
    output logic                   Enable_Output,
    output logic [Word_Length-1:0] Data_Output,
    output logic                   Valid_Output,
    output logic                   Last_Output,
    output logic                   Flag_Output,
    input  logic                   Ready_Input,
    output logic [7:0]             Row_Count_Output
);

    localparam int AW = $clog2(Depth);
    localparam int EW = Word_Length + 2;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(Depth);
    localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Entry layout: {data, last, flag}
    logic [EW-1:0] mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occupancy;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;

    // Handshake decode from registered occupancy; Ready_Input never reaches Enable_Output.
    assign Enable_Output = (occupancy < FULL_CNT);
    assign Valid_Output  = (occupancy != '0);
    assign push          = Valid_Input & Enable_Output;
    assign pop           = Valid_Output & Ready_Input;

    // Head entry is forced to zero while empty so stale storage never leaks out.
    assign head = Valid_Output ? mem[rd_ptr] : '0;
    assign {Data_Output, Last_Output, Flag_Output} = head;

    // Storage write at the tail; a synchronous clear discards the beat offered at that edge.
    always_ff @(posedge clk) begin
        if (push && !sys_reset && !reset) begin
            mem[wr_ptr] <= {Data_Input, Last_Input, Flag_Input};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at Depth-1 -> 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (sys_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef COLLECTOR_ROW_COUNT_EN
    logic [7:0] row_count;

    // Count completed rows as their Last beat leaves downstream; wraps modulo 256.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_count <= '0;
        end else if (sys_reset) begin
            row_count <= '0;
        end else if (pop && Last_Output) begin
            row_count <= row_count + 8'd1;
        end
    end

    assign Row_Count_Output = row_count;
`else
    assign Row_Count_Output = '0;
`endif

endmodule
